lfsr_job_ctrl: RTL and testbench

Bus-mapped job sequencer for the `LFSR_MultiStage` unit on the UDM `MemSplit32` bus. Software writes a seed and an iteration count, then a go bit. The block resets the LFSR, issues start pulses, waits on busy, and captures each result into a small FIFO that software drains over the bus. It replaces direct CSR poking of seed/start/reset/busy in the board top with a self-timed, optionally chained batch engine that includes a watchdog.

---
 rtl/lfsr_job_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_lfsr_job_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_job_ctrl.sv
// lfsr_job_ctrl: bus-mapped job sequencer for an LFSR unit.
// Software writes SEED/COUNT and then a go bit in CTRL. The engine pulses the
// LFSR reset, issues one start per iteration, waits for busy to drop and pushes
// each result into a small FIFO. Chained mode feeds each result back as the
// next seed. A down-counting watchdog aborts a job when the LFSR hangs.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no job; accepts go, SEED and COUNT writes
// RSTP    | one-cycle LFSR reset pulse at job start
// ISSUE   | lfsr_start_o high for one cycle with the current seed
// ARM     | busy ignored for one cycle; watchdog reloads
// WAIT    | waits for busy low; watchdog runs toward terminal count
// CAPTURE | pushes the result, or holds while the FIFO is full
module lfsr_job_ctrl #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0100,
  parameter int          FIFO_DEPTH_POW = 3,
  parameter int          TIMEOUT        = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        bus_req_i,
  input  logic        bus_we_i,
  input  logic [31:0] bus_addr_bi,
  input  logic [3:0]  bus_be_bi,
  input  logic [31:0] bus_wdata_bi,
  output logic        bus_ack_o,
  output logic        bus_resp_o,
  output logic [31:0] bus_rdata_bo,
  output logic [31:0] lfsr_seed_o,
  output logic        lfsr_start_o,
  output logic        lfsr_rst_o,
  input  logic        lfsr_busy_i,
  input  logic [31:0] lfsr_out_i,
  output logic        done_o
);

  localparam int DEPTH = 1 << FIFO_DEPTH_POW;
  localparam int WDW   = $clog2(TIMEOUT + 1);

  localparam logic [FIFO_DEPTH_POW-1:0] PTR_ONE  = FIFO_DEPTH_POW'(1);
  localparam logic [FIFO_DEPTH_POW:0]   LVL_ONE  = (FIFO_DEPTH_POW + 1)'(1);
  localparam logic [FIFO_DEPTH_POW:0]   LVL_FULL = (FIFO_DEPTH_POW + 1)'(DEPTH);
  localparam logic [WDW-1:0]            WD_LOAD  = WDW'(TIMEOUT - 1);
  localparam logic [WDW-1:0]            WD_ONE   = WDW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_RSTP, S_ISSUE, S_ARM, S_WAIT, S_CAPTURE
  } state_t;

  state_t state_q, state_d;

  logic [31:0] seed_q, cur_seed_q;
  logic [15:0] count_q, rem_q;
  logic        chain_q;
  logic [WDW-1:0] wdog_q;
  logic        timeout_err_q, underflow_q;
  logic        evt_q;
  logic        resp_q;
  logic [31:0] rdata_q;

  logic [31:0] fifo_mem [DEPTH];
  logic [FIFO_DEPTH_POW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_DEPTH_POW:0]   level_q;

  // Byte enables are ignored: every access is a full word.
  logic unused_be;
  assign unused_be = ^bus_be_bi;

  logic [31:0] addr_off;
  logic [2:0]  reg_idx;
  logic        wr, rd, ctrl_wr, seed_wr, count_wr, result_rd;
  logic        running, fifo_empty, fifo_full;
  logic        go_fire, abort_fire, timeout_fire, push, pop, last_iter, wdog_tc;
  logic [31:0] status_w, rd_mux;

  assign addr_off  = bus_addr_bi - BASE_ADDR;
  assign bus_ack_o = bus_req_i && (addr_off < 32'd32);
  assign reg_idx   = addr_off[4:2];
  assign wr        = bus_ack_o && bus_we_i;
  assign rd        = bus_ack_o && !bus_we_i;
  assign ctrl_wr   = wr && (reg_idx == 3'd0);
  assign seed_wr   = wr && (reg_idx == 3'd1);
  assign count_wr  = wr && (reg_idx == 3'd2);
  assign result_rd = rd && (reg_idx == 3'd4);

  assign running    = (state_q != S_IDLE);
  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LVL_FULL);
  assign wdog_tc    = (wdog_q == '0);
  assign last_iter  = (rem_q <= 16'd1);

  // Abort beats go when both arrive together; go needs a nonzero COUNT.
  assign go_fire      = ctrl_wr && bus_wdata_bi[0] && !bus_wdata_bi[1]
                        && !running && (count_q != 16'd0);
  assign abort_fire   = ctrl_wr && bus_wdata_bi[1] && running;
  assign timeout_fire = (state_q == S_WAIT) && lfsr_busy_i && wdog_tc && !abort_fire;
  assign pop          = result_rd && !fifo_empty;
  assign push         = (state_q == S_CAPTURE) && !abort_fire && (!fifo_full || pop);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (go_fire) state_d = S_RSTP;
      S_RSTP:    state_d = S_ISSUE;
      S_ISSUE:   state_d = S_ARM;
      S_ARM:     state_d = S_WAIT;
      S_WAIT: begin
        if (!lfsr_busy_i) state_d = S_CAPTURE;
        else if (wdog_tc) state_d = S_IDLE;
      end
      S_CAPTURE: if (push) state_d = last_iter ? S_IDLE : S_ISSUE;
      default:   state_d = S_IDLE;
    endcase
    if (abort_fire) state_d = S_IDLE;
  end

  // Outputs: state-decoded pulses plus the registered abort/timeout event.
  always_comb begin
    lfsr_start_o = (state_q == S_ISSUE);
    lfsr_rst_o   = (state_q == S_RSTP) || evt_q;
    done_o       = ((state_q == S_CAPTURE) && push && last_iter) || evt_q;
  end

  // Job datapath, configuration registers, sticky flags and watchdog.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      seed_q        <= '0;
      count_q       <= '0;
      cur_seed_q    <= '0;
      rem_q         <= '0;
      chain_q       <= 1'b0;
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
      underflow_q   <= 1'b0;
      evt_q         <= 1'b0;
    end else begin
      evt_q <= abort_fire || timeout_fire;
      if (seed_wr && !running)  seed_q  <= bus_wdata_bi;
      if (count_wr && !running) count_q <= bus_wdata_bi[15:0];
      if (go_fire) begin
        chain_q    <= bus_wdata_bi[2];
        cur_seed_q <= seed_q;
        rem_q      <= count_q;
      end else if (push) begin
        if (chain_q) cur_seed_q <= lfsr_out_i;
        if (rem_q != 16'd0) rem_q <= rem_q - 16'd1;
      end
      if (state_q == S_ARM)                wdog_q <= WD_LOAD;
      else if (state_q == S_WAIT && !wdog_tc) wdog_q <= wdog_q - WD_ONE;
      if (ctrl_wr && bus_wdata_bi[3]) begin
        timeout_err_q <= 1'b0;
        underflow_q   <= 1'b0;
      end
      if (timeout_fire) timeout_err_q <= 1'b1;
      if (result_rd && fifo_empty) underflow_q <= 1'b1;
    end
  end

  // FIFO storage; contents are only observable through the level-qualified read.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= lfsr_out_i;
  end

  // FIFO pointers and level; simultaneous push and pop leave the level unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (push && !pop)      level_q <= level_q + LVL_ONE;
      else if (pop && !push) level_q <= level_q - LVL_ONE;
    end
  end

  assign status_w = {rem_q, 4'b0, 4'(level_q), 3'b0,
                     underflow_q, timeout_err_q, fifo_full, fifo_empty, running};

  // Read mux, sampled at the access edge.
  always_comb begin
    rd_mux = '0;
    unique case (reg_idx)
      3'd1:    rd_mux = seed_q;
      3'd2:    rd_mux = {16'b0, count_q};
      3'd3:    rd_mux = status_w;
      3'd4:    rd_mux = fifo_empty ? 32'b0 : fifo_mem[rd_ptr_q];
      default: rd_mux = '0;
    endcase
  end

  // One-cycle read response; data is forced to zero outside the response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      resp_q  <= rd;
      rdata_q <= rd ? rd_mux : 32'b0;
    end
  end

  assign bus_resp_o   = resp_q;
  assign bus_rdata_bo = rdata_q;
  assign lfsr_seed_o  = cur_seed_q;

endmodule

// File: tb/tb_lfsr_job_ctrl.sv
// Bench for lfsr_job_ctrl with a stub LFSR (busy for 3 cycles, out = ~seed).
// Expected RESULT words are queued when a job is launched and popped on read.
module tb_lfsr_job_ctrl;

  localparam logic [31:0] BASE     = 32'h0000_0100;
  localparam logic [31:0] A_CTRL   = BASE + 32'h00;
  localparam logic [31:0] A_SEED   = BASE + 32'h04;
  localparam logic [31:0] A_COUNT  = BASE + 32'h08;
  localparam logic [31:0] A_STATUS = BASE + 32'h0C;
  localparam logic [31:0] A_RESULT = BASE + 32'h10;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        bus_req_i, bus_we_i;
  logic [31:0] bus_addr_bi, bus_wdata_bi;
  logic [3:0]  bus_be_bi;
  logic        bus_ack_o, bus_resp_o;
  logic [31:0] bus_rdata_bo, lfsr_seed_o, lfsr_out_i;
  logic        lfsr_start_o, lfsr_rst_o, lfsr_busy_i, done_o;

  lfsr_job_ctrl #(.BASE_ADDR(BASE), .FIFO_DEPTH_POW(3), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .bus_req_i(bus_req_i), .bus_we_i(bus_we_i), .bus_addr_bi(bus_addr_bi),
    .bus_be_bi(bus_be_bi), .bus_wdata_bi(bus_wdata_bi),
    .bus_ack_o(bus_ack_o), .bus_resp_o(bus_resp_o), .bus_rdata_bo(bus_rdata_bo),
    .lfsr_seed_o(lfsr_seed_o), .lfsr_start_o(lfsr_start_o), .lfsr_rst_o(lfsr_rst_o),
    .lfsr_busy_i(lfsr_busy_i), .lfsr_out_i(lfsr_out_i), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  // Stub LFSR.
  int   busy_cnt;
  logic stuck = 1'b0;
  always @(posedge clk_i) begin
    if (rst_i) begin
      busy_cnt   <= 0;
      lfsr_out_i <= '0;
    end else if (lfsr_start_o) begin
      busy_cnt   <= 3;
      lfsr_out_i <= lfsr_seed_o ^ 32'hFFFF_FFFF;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end
  assign lfsr_busy_i = stuck || (busy_cnt != 0);

  // Pulse counters.
  int done_cnt = 0;
  int rst_cnt  = 0;
  always @(negedge clk_i) begin
    if (done_o)     done_cnt <= done_cnt + 1;
    if (lfsr_rst_o) rst_cnt  <= rst_cnt + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus_req_i = 1'b1; bus_we_i = 1'b1; bus_addr_bi = addr; bus_wdata_bi = data;
    tick;
    bus_req_i = 1'b0; bus_we_i = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_bi = addr;
    tick;
    bus_req_i = 1'b0;
    check("read_resp", {31'b0, bus_resp_o}, 32'd1);
    data = bus_rdata_bo;
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(addr, d);
    check(tag, d, exp);
  endtask

  task automatic rd_result(input string tag);
    logic [31:0] d, e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'h0;
    bus_read(A_RESULT, d);
    check(tag, d, e);
  endtask

  task automatic wait_done(input string tag, input int base, input int budget);
    int n = 0;
    while (done_cnt <= base && n < budget) begin
      tick;
      n++;
    end
    check(tag, {31'b0, done_cnt > base}, 32'd1);
  endtask

  task automatic queue_job(input logic [31:0] seed, input int count, input logic chain);
    logic [31:0] s = seed;
    for (int i = 0; i < count; i++) begin
      exp_q.push_back(~s);
      if (chain) s = ~s;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int n, d0, r0;
    rst_i = 1'b1; bus_req_i = 1'b0; bus_we_i = 1'b0;
    bus_addr_bi = '0; bus_wdata_bi = '0; bus_be_bi = 4'hF;

    // Reset
    tick; tick;
    check("rst_outs", {29'b0, bus_resp_o, lfsr_start_o, lfsr_rst_o},
          32'd0);
    check("rst_data", bus_rdata_bo | lfsr_seed_o, 32'd0);
    check("rst_done", {31'b0, done_o}, 32'd0);
    rst_i = 1'b0;
    tick;
    check("post_rst_outs", {27'b0, bus_ack_o, bus_resp_o, lfsr_start_o, lfsr_rst_o, done_o}, 32'd0);
    read_check("status_reset", A_STATUS, 32'h0000_0002);
    tick;
    check("rdata_idle_zero", bus_rdata_bo, 32'd0);

    // Window decode and unmapped offsets
    bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_bi = BASE + 32'd32;
    #1 check("ack_out_window", {31'b0, bus_ack_o}, 32'd0);
    bus_addr_bi = BASE - 32'd4;
    #1 check("ack_below_window", {31'b0, bus_ack_o}, 32'd0);
    bus_addr_bi = BASE + 32'd28;
    #1 check("ack_in_window", {31'b0, bus_ack_o}, 32'd1);
    bus_req_i = 1'b0;
    read_check("unmapped_read", BASE + 32'h14, 32'd0);

    // Single job with exact pulse timing
    bus_write(A_SEED, 32'h1234_5678);
    bus_write(A_COUNT, 32'hABCD_0001);
    read_check("seed_rb", A_SEED, 32'h1234_5678);
    read_check("count_rb", A_COUNT, 32'h0000_0001);
    queue_job(32'h1234_5678, 1, 1'b0);
    d0 = done_cnt;
    bus_write(A_CTRL, 32'h1);
    check("single_rstp", {30'b0, lfsr_rst_o, lfsr_start_o}, 32'b10);
    tick;
    check("single_issue", {30'b0, lfsr_rst_o, lfsr_start_o}, 32'b01);
    check("single_seed_o", lfsr_seed_o, 32'h1234_5678);
    n = 0;
    do begin
      tick;
      n++;
    end while (!done_o && n < 20);
    check("single_done_latency", n, 32'd5);
    tick;
    check("single_done_count", done_cnt - d0, 32'd1);
    rd_result("single_result");
    read_check("single_status", A_STATUS, 32'h0000_0002);

    // Chained batch
    bus_write(A_COUNT, 32'd4);
    queue_job(32'h1234_5678, 4, 1'b1);
    d0 = done_cnt;
    bus_write(A_CTRL, 32'h5);
    wait_done("chain_done", d0, 100);
    for (int i = 0; i < 4; i++) rd_result("chain_result");

    // Backpressure with a full FIFO
    bus_write(A_COUNT, 32'd10);
    queue_job(32'h1234_5678, 10, 1'b1);
    d0 = done_cnt;
    bus_write(A_CTRL, 32'h5);
    repeat (150) tick;
    read_check("bp_status_full", A_STATUS, 32'h0002_0805);
    check("bp_no_done", done_cnt - d0, 32'd0);
    rd_result("bp_result");
    rd_result("bp_result");
    wait_done("bp_done", d0, 100);
    for (int i = 0; i < 8; i++) rd_result("bp_result");
    rd_result("bp_underflow_read");
    read_check("bp_status_underflow", A_STATUS, 32'h0000_0012);

    // Timeout with busy stuck high
    bus_write(A_CTRL, 32'h8);
    read_check("clear_status", A_STATUS, 32'h0000_0002);
    stuck = 1'b1;
    bus_write(A_COUNT, 32'd1);
    d0 = done_cnt;
    r0 = rst_cnt;
    bus_write(A_CTRL, 32'h1);
    wait_done("to_done", d0, 100);
    check("to_rst_pulses", rst_cnt - r0, 32'd2);
    read_check("to_status", A_STATUS, 32'h0001_000A);
    stuck = 1'b0;
    bus_write(A_CTRL, 32'h8);
    read_check("to_status_cleared", A_STATUS, 32'h0001_0002);

    // Abort during WAIT, ignored SEED write while running
    bus_write(A_COUNT, 32'd5);
    queue_job(32'h1234_5678, 1, 1'b0);
    d0 = done_cnt;
    bus_write(A_CTRL, 32'h1);
    bus_write(A_SEED, 32'hDEAD_BEEF);
    repeat (8) tick;
    bus_write(A_CTRL, 32'h2);
    check("abort_pulses", {30'b0, done_o, lfsr_rst_o}, 32'b11);
    tick;
    check("abort_done_count", done_cnt - d0, 32'd1);
    read_check("abort_status", A_STATUS, 32'h0004_0100);
    read_check("abort_seed_kept", A_SEED, 32'h1234_5678);
    rd_result("abort_result");
    bus_write(A_CTRL, 32'h3);
    tick;
    read_check("go_abort_idle", A_STATUS, 32'h0004_0002);

    // Reset in the middle of a job
    bus_write(A_CTRL, 32'h1);
    repeat (4) tick;
    d0 = done_cnt;
    rst_i = 1'b1;
    tick;
    rst_i = 1'b0;
    check("midrst_outs", {29'b0, lfsr_start_o, lfsr_rst_o, done_o}, 32'd0);
    repeat (10) tick;
    check("midrst_no_done", done_cnt - d0, 32'd0);
    read_check("midrst_status", A_STATUS, 32'h0000_0002);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
